gpa_fhdo_seq: RTL and testbench
===============================

GPA_FHDO_SEQ -- requirements
Module: gpa_fhdo_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, gradient BRAM address width (max 1024 words).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_i  input  1  one-cycle pulse that begins playback.
REQ-005 SHALL have port stop_i  input  1  one-cycle pulse that aborts playback.
REQ-006 SHALL have port word_count_i  input  ADDR_WIDTH+1  number of words to play, 0..2^ADDR_WIDTH.
REQ-007 SHALL have port interval_i  input  16  clock cycles between successive word issues.
REQ-008 SHALL have port loop_i  input  1  repeat playback from address 0.
REQ-009 SHALL have port mem_addr_o  output  ADDR_WIDTH  BRAM read address.
REQ-010 SHALL have port mem_data_i  input  32  BRAM read data, valid one cycle after the address.
REQ-011 SHALL have port data_o  output  32  word sent to the DAC serialiser.
REQ-012 SHALL have port valid_o  output  1  one-cycle issue strobe to the serialiser.
REQ-013 SHALL have port busy_i  input  1  serialiser busy flag.
REQ-014 SHALL have port running_o  output  1  high in every non-IDLE state.
REQ-015 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-016 SHALL have port underrun_o  output  1  sticky flag: slot missed because busy_i was high.

Function
REQ-017 SHALL implement states IDLE, FETCH, LATCH, WAIT_SLOT, ISSUE.
REQ-018 SHALL, in IDLE, on start_i with word_count_i!=0:
- latch word_count_i and interval_i;
- set the effective interval to max(interval_i,4);
- set index=0, clear underrun_o, preset the slot counter to "due";
- go to FETCH.
REQ-019 SHALL, in IDLE, on start_i with word_count_i==0, pulse done_o on the next cycle and stay IDLE.
REQ-020 SHALL, in FETCH, drive mem_addr_o=index and go to LATCH.
REQ-021 SHALL, in LATCH, register mem_data_i into data_o and go to WAIT_SLOT.
REQ-022 SHALL run a 16-bit slot counter:
- cleared to 0 on entering ISSUE;
- +1 per cycle;
- saturating at the effective interval.
REQ-023 SHALL treat the slot as "due" when counter >= interval-2; with busy_i low, successive valid_o pulses are then exactly interval cycles apart.
REQ-024 SHALL, in WAIT_SLOT, go to ISSUE when the slot is due and busy_i==0.
REQ-025 SHALL, when the slot is due and busy_i==1, set underrun_o and keep waiting; issue happens on the first cycle busy_i is low.
REQ-026 SHALL assert valid_o for exactly the ISSUE cycle, with data_o stable from LATCH until the next LATCH.
REQ-027 SHALL, in ISSUE, go to FETCH with index+1 when index < count-1.
REQ-028 SHALL, in ISSUE on the last word, go to IDLE and pulse done_o on the following cycle.
REQ-029 SHALL give a first-issue latency of 4 cycles: start_i sampled at cycle 0 gives valid_o at cycle 4 when busy_i is low.
REQ-030 SHALL, on stop_i in any non-IDLE state:
- go to IDLE on the next edge;
- suppress any pending valid_o;
- not pulse done_o;
- hold underrun_o.
REQ-031 SHALL give stop_i priority when start_i and stop_i are coincident; start_i while running is ignored.
REQ-032 SHALL not sample or latch word_count_i, interval_i or loop_i mid-run; the latched values are used.

Reset
REQ-033 SHALL, on rst high, immediately force: state=IDLE, mem_addr_o=0, data_o=0, valid_o=0, running_o=0, done_o=0, underrun_o=0, index=0, counter=0.
REQ-034 SHALL, on rst asserted mid-run, abort the run with no valid_o or done_o emitted after rst rises.

Configuration
REQ-035 SHALL, when GPA_SEQ_LOOP_EN is defined and loop_i (latched at start) is 1, wrap index to 0 at the last ISSUE instead of finishing, with no done_o; only stop_i or rst ends the run.
REQ-036 SHALL, when GPA_SEQ_LOOP_EN is undefined, keep the loop_i port but ignore it, so playback always ends per REQ-028.

Verification
REQ-037 SHALL cover: count=3, interval=10, busy_i=0, start_i at cycle 0 -> valid_o at cycles 4,14,24 with data_o=mem[0..2], done_o at cycle 25.
REQ-038 SHALL cover: interval_i=1, count=2 -> valid_o spacing 4 cycles (clamped).
REQ-039 SHALL cover: busy_i held high from cycle 10 to 30, interval=10 -> second valid_o at cycle 31, underrun_o=1 until the next start_i.
REQ-040 SHALL cover: stop_i at cycle 8 of a count=5 run -> no further valid_o, no done_o, running_o=0 at cycle 9.
REQ-041 SHALL cover: start_i and stop_i coincident in IDLE -> remains IDLE; count=0 start -> done_o only, no valid_o.
REQ-042 SHALL cover: with GPA_SEQ_LOOP_EN defined, loop_i=1, count=2 -> issues mem[0],mem[1],mem[0],... with no done_o; with the macro undefined -> done_o after 2 issues.

Source files
------------

// File: rtl/gpa_fhdo_seq.sv
`default_nettype none
// ============================================================================
// Module      : gpa_fhdo_seq
// Description : Gradient waveform playback sequencer for the GPA-FHDO DAC.
//               Reads words from a gradient BRAM with one cycle of read
//               latency and hands them to the DAC serialiser at a fixed,
//               programmable issue interval. The interval is never shorter
//               than 4 cycles. If the serialiser is still busy when an issue
//               slot comes due, the issue is held back and a sticky underrun
//               flag is raised.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   GPA_SEQ_LOOP_EN  When defined, a run started with loop_i=1 wraps back to
//                    address 0 after the last word. Only stop_i or rst ends
//                    such a run. When undefined, loop_i is accepted but has
//                    no effect.
// ----------------------------------------------------------------------------
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   start_i       in   one-cycle pulse that begins playback (IDLE only)
//   stop_i        in   one-cycle pulse that aborts playback
//   word_count_i  in   [ADDR_WIDTH:0] number of words to play, 0..2^ADDR_WIDTH
//   interval_i    in   [15:0] cycles between successive issues
//   loop_i        in   repeat playback from address 0 (see build option)
//   mem_addr_o    out  [ADDR_WIDTH-1:0] BRAM read address
//   mem_data_i    in   [31:0] BRAM read data, valid one cycle after address
//   data_o        out  [31:0] word presented to the serialiser
//   valid_o       out  one-cycle issue strobe
//   busy_i        in   serialiser busy flag
//   running_o     out  high while the sequencer is not idle
//   done_o        out  one-cycle completion pulse
//   underrun_o    out  sticky: an issue slot was missed because of busy_i
// ============================================================================
module gpa_fhdo_seq #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [ADDR_WIDTH:0]   word_count_i,
  input  logic [15:0]           interval_i,
  input  logic                  loop_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [31:0]           mem_data_i,
  output logic [31:0]           data_o,
  output logic                  valid_o,
  input  logic                  busy_i,
  output logic                  running_o,
  output logic                  done_o,
  output logic                  underrun_o
);

  // Shortest interval the fetch/latch/wait/issue pipeline can sustain.
  localparam logic [15:0] C_MIN_INTERVAL = 16'd4;
  // The slot is due two cycles before the interval expires: the due decision
  // is taken in WAIT_SLOT and the counter only restarts after ISSUE, which
  // together absorb two cycles of the interval.
  localparam logic [15:0] C_DUE_LEAD     = 16'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LATCH     = 3'd2,
    ST_WAIT_SLOT = 3'd3,
    ST_ISSUE     = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_WIDTH:0]   r_count;
  logic [15:0]           r_interval;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [15:0]           r_slot_cnt;
  logic [31:0]           r_data;
  logic                  r_valid;
  logic                  r_done;
  logic                  r_underrun;

  logic [15:0]           w_interval_eff;
  logic                  w_start_run;
  logic                  w_start_empty;
  logic                  w_slot_due;
  logic                  w_last_word;
  logic                  w_wrap;
  logic                  w_finish;
  logic                  w_advance;

  // --------------------------------------------------------------------------
  // Loop option
  // --------------------------------------------------------------------------
`ifdef GPA_SEQ_LOOP_EN
  logic r_loop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_loop <= 1'b0;
    end else if (w_start_run) begin
      r_loop <= loop_i;
    end
  end

  assign w_wrap = r_loop;
`else
  logic w_unused_loop;

  assign w_unused_loop = loop_i;
  assign w_wrap        = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  assign w_interval_eff = (interval_i < C_MIN_INTERVAL) ? C_MIN_INTERVAL : interval_i;

  // stop_i wins over a coincident start_i, and start_i is only honoured in IDLE.
  assign w_start_run   = (r_state == ST_IDLE) && start_i && !stop_i &&
                         (word_count_i != '0);
  assign w_start_empty = (r_state == ST_IDLE) && start_i && !stop_i &&
                         (word_count_i == '0);

  assign w_slot_due  = (r_slot_cnt >= (r_interval - C_DUE_LEAD));

  // r_count is never zero during a run, so count-1 cannot underflow here.
  assign w_last_word = ({1'b0, r_index} == (r_count - (ADDR_WIDTH+1)'(1)));

  // Normal completion: last word issued, not looping, and not aborted.
  assign w_finish  = (r_state == ST_ISSUE) && w_last_word && !w_wrap && !stop_i;
  // Going back to FETCH for another word (either the next one or a wrap to 0).
  assign w_advance = (r_state == ST_ISSUE) && (w_state_next == ST_FETCH);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_run) begin
          w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_state_next = ST_LATCH;
      end
      ST_LATCH: begin
        w_state_next = ST_WAIT_SLOT;
      end
      ST_WAIT_SLOT: begin
        if (w_slot_due && !busy_i) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!w_last_word || w_wrap) begin
          w_state_next = ST_FETCH;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // An abort overrides any transition, including a pending issue.
    if (stop_i && (r_state != ST_IDLE)) begin
      w_state_next = ST_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Run parameters, word index and slot counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_interval <= '0;
      r_index    <= '0;
      r_slot_cnt <= '0;
    end else if (w_start_run) begin
      r_count    <= word_count_i;
      r_interval <= w_interval_eff;
      r_index    <= '0;
      // Preset to the saturated value so the first word issues as soon as
      // it has been fetched.
      r_slot_cnt <= w_interval_eff;
    end else begin
      if (w_advance) begin
        if (w_last_word) begin
          r_index <= '0;
        end else begin
          r_index <= r_index + ADDR_WIDTH'(1);
        end
      end

      if (r_state == ST_ISSUE) begin
        r_slot_cnt <= '0;
      end else if (r_slot_cnt < r_interval) begin
        r_slot_cnt <= r_slot_cnt + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Data path and status outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      // The BRAM word addressed in FETCH arrives during LATCH; it then stays
      // on data_o until the next word is latched.
      if (r_state == ST_LATCH) begin
        r_data <= mem_data_i;
      end

      // Registered from the next state so the strobe covers exactly the
      // ISSUE cycle and an abort before ISSUE suppresses it.
      r_valid <= (w_state_next == ST_ISSUE);
      r_done  <= w_finish || w_start_empty;

      if (w_start_run) begin
        r_underrun <= 1'b0;
      end else if ((r_state == ST_WAIT_SLOT) && w_slot_due && busy_i) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign mem_addr_o = r_index;
  assign data_o     = r_data;
  assign valid_o    = r_valid;
  assign done_o     = r_done;
  assign underrun_o = r_underrun;
  assign running_o  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gpa_fhdo_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpa_fhdo_seq
// Description : Self-checking bench for gpa_fhdo_seq. Table-driven playback
//               scenarios with hand-computed issue/done cycles, plus
//               hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpa_fhdo_seq;

  localparam int AW = 10;
  localparam int W  = 40;   // cycles observed per scenario
  localparam int NV = 6;    // max expected issues per scenario

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          stop_i;
  logic [AW:0]   word_count_i;
  logic [15:0]   interval_i;
  logic          loop_i;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_data_i;
  logic [31:0]   data_o;
  logic          valid_o;
  logic          busy_i;
  logic          running_o;
  logic          done_o;
  logic          underrun_o;

  gpa_fhdo_seq #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .word_count_i (word_count_i),
    .interval_i   (interval_i),
    .loop_i       (loop_i),
    .mem_addr_o   (mem_addr_o),
    .mem_data_i   (mem_data_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .busy_i       (busy_i),
    .running_o    (running_o),
    .done_o       (done_o),
    .underrun_o   (underrun_o)
  );

  always #5 clk = ~clk;

  // BRAM model: one cycle of read latency.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) mem_data_i <= mem[mem_addr_o];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int count;
    int interval;
    bit loop;
    int busy_from;    // busy_i high for cycles [busy_from, busy_to)
    int busy_to;
    int stop_at;      // cycle of stop_i pulse, -1 none (0 = with start_i)
    int nvalid;
    int v [NV];       // expected valid_o cycles
    int done_at;      // expected done_o cycle, -1 none
    bit exp_underrun; // underrun_o at end of window
    int run_cyc;      // cycle where running_o is checked
    bit exp_run;
  } vec_t;

  vec_t vecs [10];
  int   nvec = 0;

  task automatic add_vec(input int count, input int interval, input bit loop,
                         input int bf, input int bt, input int stop_at,
                         input int done_at, input bit und, input int run_cyc,
                         input bit run_exp, input int n,
                         input int v0, input int v1, input int v2,
                         input int v3, input int v4, input int v5);
    vec_t t;
    t.count = count; t.interval = interval; t.loop = loop;
    t.busy_from = bf; t.busy_to = bt; t.stop_at = stop_at;
    t.done_at = done_at; t.exp_underrun = und;
    t.run_cyc = run_cyc; t.exp_run = run_exp; t.nvalid = n;
    t.v[0] = v0; t.v[1] = v1; t.v[2] = v2; t.v[3] = v3; t.v[4] = v4; t.v[5] = v5;
    vecs[nvec] = t;
    nvec++;
  endtask

  // Entered just after a rising edge; cycle 0 is the cycle start_i is high.
  task automatic run_vec(input int idx);
    vec_t t;
    int   k;
    bit   exp_v;
    logic [31:0] wc;
    logic [31:0] iv;
    t  = vecs[idx];
    k  = 0;
    wc = t.count;
    iv = t.interval;
    word_count_i = wc[AW:0];
    interval_i   = iv[15:0];
    loop_i       = t.loop;
    for (int c = 0; c < W; c++) begin
      start_i = (c == 0);
      stop_i  = (c == t.stop_at);
      busy_i  = (c >= t.busy_from) && (c < t.busy_to);
      @(negedge clk);
      exp_v = (k < t.nvalid) && (t.v[k] == c);
      chk($sformatf("v%0d c%0d valid_o", idx, c), 32'(valid_o), 32'(exp_v));
      if (exp_v) begin
        chk($sformatf("v%0d c%0d data_o", idx, c), data_o, mem[k % t.count]);
        k++;
      end
      chk($sformatf("v%0d c%0d done_o", idx, c), 32'(done_o), 32'(c == t.done_at));
      if (c == t.run_cyc) begin
        chk($sformatf("v%0d c%0d running_o", idx, c), 32'(running_o), 32'(t.exp_run));
      end
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    stop_i  = 1'b0;
    busy_i  = 1'b0;
    chk($sformatf("v%0d underrun_o", idx), 32'(underrun_o), 32'(t.exp_underrun));
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 32'hA5A5_0000 + i * 32'h0001_0103;
    end

    //       cnt int lp bf bt stop done und rc re  n  valid cycles
    add_vec(3, 10, 0, 0, 0, -1, 25, 0, 24, 1, 3, 4, 14, 24, -1, -1, -1);
    add_vec(2,  1, 0, 0, 0, -1,  9, 0,  9, 0, 2, 4,  8, -1, -1, -1, -1);
    add_vec(2, 10, 0, 10, 30, -1, 32, 1, 20, 1, 2, 4, 31, -1, -1, -1, -1);
    add_vec(5, 10, 0, 0, 0,  8, -1, 0,  9, 0, 1, 4, -1, -1, -1, -1, -1);
    add_vec(3, 10, 0, 0, 0,  0, -1, 0,  1, 0, 0, -1, -1, -1, -1, -1, -1);
    add_vec(0, 10, 0, 0, 0, -1,  1, 0,  1, 0, 0, -1, -1, -1, -1, -1, -1);
    add_vec(3,  5, 0, 0, 0, -1, 15, 0, 15, 0, 3, 4,  9, 14, -1, -1, -1);
    add_vec(1,  4, 0, 0, 0, -1,  5, 0,  4, 1, 1, 4, -1, -1, -1, -1, -1);
`ifdef GPA_SEQ_LOOP_EN
    add_vec(2,  4, 1, 0, 0, 17, -1, 0, 12, 1, 4, 4,  8, 12, 16, -1, -1);
`else
    add_vec(2,  4, 1, 0, 0, 17,  9, 0, 12, 0, 2, 4,  8, -1, -1, -1, -1);
`endif

    // Reset state
    rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; busy_i = 1'b0; loop_i = 1'b0;
    word_count_i = '0; interval_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst valid_o",    32'(valid_o),    32'd0);
    chk("rst done_o",     32'(done_o),     32'd0);
    chk("rst running_o",  32'(running_o),  32'd0);
    chk("rst underrun_o", 32'(underrun_o), 32'd0);
    chk("rst data_o",     data_o,          32'd0);
    chk("rst mem_addr_o", 32'(mem_addr_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < nvec; i++) begin
      run_vec(i);
    end

    // Reset in the middle of a run: immediate clear, nothing emitted after.
    word_count_i = 11'd3;
    interval_i   = 16'd10;
    for (int c = 0; c < 36; c++) begin
      start_i = (c == 0);
      if (c == 6) begin
        rst = 1'b1;
        #1;
        chk("midrst running_o", 32'(running_o), 32'd0);
        chk("midrst valid_o",   32'(valid_o),   32'd0);
        chk("midrst data_o",    data_o,         32'd0);
      end
      if (c == 8) rst = 1'b0;
      @(negedge clk);
      if (c == 5) chk("prerst running_o", 32'(running_o), 32'd1);
      if (c >= 6) begin
        chk($sformatf("midrst c%0d valid_o", c), 32'(valid_o), 32'd0);
        chk($sformatf("midrst c%0d done_o", c),  32'(done_o),  32'd0);
      end
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
